// File: rtl/video_pattern_pkg.sv
// Shared types and colour constants for the multi-pattern video generator.
package video_pattern_pkg;

   typedef enum logic [1:0] {
      BARS    = 2'd0,
      RAMP    = 2'd1,
      CHECKER = 2'd2,
      SOLID   = 2'd3
   } pattern_t;

   // Bar colours as {R,G,B} on/off masks, in left-to-right lane order.
   localparam logic [2:0] BAR_BLACK   = 3'b000;
   localparam logic [2:0] BAR_BLUE    = 3'b001;
   localparam logic [2:0] BAR_GREEN   = 3'b010;
   localparam logic [2:0] BAR_CYAN    = 3'b011;
   localparam logic [2:0] BAR_RED     = 3'b100;
   localparam logic [2:0] BAR_MAGENTA = 3'b101;
   localparam logic [2:0] BAR_YELLOW  = 3'b110;
   localparam logic [2:0] BAR_WHITE   = 3'b111;

   function automatic logic [2:0] bar_mask(input logic [2:0] lane);
      case (lane)
         3'd0:    return BAR_BLACK;
         3'd1:    return BAR_BLUE;
         3'd2:    return BAR_GREEN;
         3'd3:    return BAR_CYAN;
         3'd4:    return BAR_RED;
         3'd5:    return BAR_MAGENTA;
         3'd6:    return BAR_YELLOW;
         default: return BAR_WHITE;
      endcase
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle carrying video beats (tuser = start of frame, tlast = end of line).
interface axi4_stream_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tuser;
   logic              tlast;

   modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_pattern_pixel.sv
// Combinational colour lookup: maps a pixel/line position and pattern to packed {R,G,B}.
module video_pattern_pixel
   import video_pattern_pkg::*;
#(
   parameter int X_ACTIVE     = 1920,
   parameter int PX_WIDTH     = 10,
   parameter int CHECKER_SIZE = 64,
   parameter int PX_CNT_W     = 11,
   parameter int LN_CNT_W     = 11
) (
   input  logic [PX_CNT_W-1:0]   px_i,
   input  logic [LN_CNT_W-1:0]   ln_i,
   input  pattern_t              pattern_i,
   input  logic [3*PX_WIDTH-1:0] solid_i,
   output logic [3*PX_WIDTH-1:0] rgb_o
);

   localparam int LANE_W = X_ACTIVE / 8;
   localparam int CB     = $clog2(CHECKER_SIZE);
   localparam int RAMP_W = PX_CNT_W + PX_WIDTH;

   logic [31:0]         bar_lane;
   logic [PX_WIDTH-1:0] ramp_val;
   logic                chk_bit;

   function automatic logic [3*PX_WIDTH-1:0] expand(input logic [2:0] m);
      return {{PX_WIDTH{m[2]}}, {PX_WIDTH{m[1]}}, {PX_WIDTH{m[0]}}};
   endfunction

   assign bar_lane = 32'(px_i) / 32'(LANE_W);
   // px*2^PX_WIDTH fits in RAMP_W bits and the quotient is always below 2^PX_WIDTH.
   assign ramp_val = PX_WIDTH'({px_i, {PX_WIDTH{1'b0}}} / RAMP_W'(X_ACTIVE));
   assign chk_bit  = (((32'(px_i) >> CB) ^ (32'(ln_i) >> CB)) & 32'd1) != 32'd0;

   always_comb begin
      // NOTE: assign a default before the case so every path drives rgb_o and no latch is inferred.
      rgb_o = '0;
      case (pattern_i)
         BARS: begin
            if (bar_lane > 32'd7) rgb_o = expand(BAR_WHITE);
            else                  rgb_o = expand(bar_mask(bar_lane[2:0]));
         end
         RAMP:    rgb_o = {3{ramp_val}};
         CHECKER: rgb_o = chk_bit ? expand(BAR_WHITE) : expand(BAR_BLACK);
         SOLID:   rgb_o = solid_i;
         default: rgb_o = '0;
      endcase
   end

endmodule

// File: rtl/axi4_video_multipattern_gen.sv
// Frame-timed AXI4-Stream test-pattern source: bars, ramp, checkerboard or solid colour,
// with horizontal/vertical blanking and a completed-frame counter.
module axi4_video_multipattern_gen
   import video_pattern_pkg::*;
#(
   parameter int X_ACTIVE     = 1920,
   parameter int Y_ACTIVE     = 1080,
   parameter int X_BLANKING   = 280,
   parameter int Y_BLANKING   = 45,
   parameter int PX_WIDTH     = 10,
   parameter int CHECKER_SIZE = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [1:0]            pattern_sel_i,
   input  logic [3*PX_WIDTH-1:0] solid_color_i,
   output logic [15:0]           frame_cnt_o,
   axi4_stream_if.master         video_o
);

   localparam int TDATA_W  = ((3 * PX_WIDTH + 7) / 8) * 8;
   localparam int PX_CNT_W = (X_ACTIVE > 1) ? $clog2(X_ACTIVE) : 1;
   localparam int LN_CNT_W = (Y_ACTIVE > 1) ? $clog2(Y_ACTIVE) : 1;
   localparam int V_CYCLES = Y_BLANKING * (X_ACTIVE + X_BLANKING);
   localparam int BLK_MAX  = (V_CYCLES > X_BLANKING) ? V_CYCLES : X_BLANKING;
   localparam int BLK_W    = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

   localparam logic [PX_CNT_W-1:0] PX_LAST = PX_CNT_W'(X_ACTIVE - 1);
   localparam logic [LN_CNT_W-1:0] LN_LAST = LN_CNT_W'(Y_ACTIVE - 1);
   localparam logic [BLK_W-1:0]    HB_LAST = BLK_W'(X_BLANKING - 1);
   localparam logic [BLK_W-1:0]    VB_LAST = BLK_W'(V_CYCLES - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACTIVE  = 2'd1;
   localparam logic [1:0] H_BLANK = 2'd2;
   localparam logic [1:0] V_BLANK = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [PX_CNT_W-1:0]   px_q, px_d;
   logic [LN_CNT_W-1:0]   ln_q, ln_d;
   logic [BLK_W-1:0]      blk_q, blk_d;
   logic [15:0]           frame_q, frame_d;
   pattern_t              pattern_q, pattern_d;
   logic [3*PX_WIDTH-1:0] solid_q, solid_d;
   logic                  tvalid_q, tvalid_d;
   logic [TDATA_W-1:0]    tdata_q, tdata_d;
   logic                  tuser_q, tuser_d;
   logic                  tlast_q, tlast_d;
   logic                  beat_acc;
   logic                  start_frame;
   logic [3*PX_WIDTH-1:0] pix_rgb;

   assign beat_acc = tvalid_q & video_o.tready;

   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      ln_d        = ln_q;
      blk_d       = blk_q;
      frame_d     = frame_q;
      pattern_d   = pattern_q;
      solid_d     = solid_q;
      start_frame = 1'b0;
      case (state_q)
         IDLE: if (enable_i) start_frame = 1'b1;
         ACTIVE: begin
            if (beat_acc) begin
               if (px_q == PX_LAST) begin
                  px_d    = '0;
                  state_d = H_BLANK;
               end else begin
                  px_d = px_q + 1'b1;
               end
            end
         end
         H_BLANK: begin
            if (blk_q == HB_LAST) begin
               blk_d = '0;
               if (ln_q == LN_LAST) begin
                  ln_d    = '0;
                  state_d = V_BLANK;
               end else begin
                  ln_d    = ln_q + 1'b1;
                  state_d = ACTIVE;
               end
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         V_BLANK: begin
            if (blk_q == VB_LAST) begin
               blk_d   = '0;
               frame_d = frame_q + 16'd1;
               if (enable_i) start_frame = 1'b1;
               else          state_d     = IDLE;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Pattern and colour are captured only at a frame start so a frame is never mixed.
      if (start_frame) begin
         state_d   = ACTIVE;
         px_d      = '0;
         ln_d      = '0;
         pattern_d = pattern_t'(pattern_sel_i);
         solid_d   = solid_color_i;
      end
   end

   video_pattern_pixel #(
      .X_ACTIVE     (X_ACTIVE),
      .PX_WIDTH     (PX_WIDTH),
      .CHECKER_SIZE (CHECKER_SIZE),
      .PX_CNT_W     (PX_CNT_W),
      .LN_CNT_W     (LN_CNT_W)
   ) u_pixel (
      .px_i      (px_d),
      .ln_i      (ln_d),
      .pattern_i (pattern_d),
      .solid_i   (solid_d),
      .rgb_o     (pix_rgb)
   );

   // Beat outputs are computed from next-state counters, so a stall reproduces the same beat.
   assign tvalid_d = (state_d == ACTIVE);
   assign tdata_d  = tvalid_d ? TDATA_W'(pix_rgb) : '0;
   assign tuser_d  = tvalid_d && (px_d == '0) && (ln_d == '0);
   assign tlast_d  = tvalid_d && (px_d == PX_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         px_q      <= '0;
         ln_q      <= '0;
         blk_q     <= '0;
         frame_q   <= '0;
         pattern_q <= BARS;
         solid_q   <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tuser_q   <= 1'b0;
         tlast_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         px_q      <= px_d;
         ln_q      <= ln_d;
         blk_q     <= blk_d;
         frame_q   <= frame_d;
         pattern_q <= pattern_d;
         solid_q   <= solid_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tuser_q   <= tuser_d;
         tlast_q   <= tlast_d;
      end
   end

   assign video_o.tvalid = tvalid_q;
   assign video_o.tdata  = tdata_q;
   assign video_o.tuser  = tuser_q;
   assign video_o.tlast  = tlast_q;
   assign frame_cnt_o    = frame_q;

endmodule
